phys_free_list: RTL and testbench
=================================

Name: phys_free_list

Overview:
- Circular FIFO of unallocated physical register IDs.
- Sits directly upstream of the register alias table in the rename stage. It supplies the dst_phys for each renamed destination and takes back the previous mapping of a destination when that instruction commits.
- Keeps a speculative head and a committed head, so a pipeline flush returns every speculatively allocated register in one cycle.

Parameters:
- NUM_PHYS_REGS, 64, total physical integer registers.
- NUM_ARCH_REGS, 32, architectural integer registers; phys 0..NUM_ARCH_REGS-1 are mapped at reset and are never in the list at reset.
- PHYS_W, 6, physical register ID width, equal to $clog2(NUM_PHYS_REGS).
- DEPTH, NUM_PHYS_REGS-NUM_ARCH_REGS (32), number of FIFO entries.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- alloc_req  in  1  rename wants one destination register this cycle.
- alloc_valid  out  1  a free register is available, combinational: !empty && !flush.
- alloc_phys  out  PHYS_W  entry at the speculative head; meaningful only when alloc_valid=1.
- commit_en  in  1  an instruction with rd!=x0 commits this cycle.
- commit_old_phys  in  PHYS_W  previous physical mapping of that rd, returned to the list.
- flush  in  1  misprediction recovery; discards all uncommitted allocations.
- free_count  out  PHYS_W  number of speculatively free entries, 0..DEPTH.
- err_overflow  out  1  sticky: a release was attempted while the list was full.
- err_underflow  out  1  sticky: commit_en was asserted with no outstanding allocation.

Behaviour:
- Storage: DEPTH entries of PHYS_W bits.
- Pointers: spec_head, commit_head and tail, each $clog2(DEPTH)+1 bits (index plus wrap bit).
- empty: spec_head == tail. full: index bits equal and wrap bits differ.
- Reset (asynchronous, rst=1):
  - entry[i] = NUM_ARCH_REGS+i, i.e. 32..63.
  - spec_head = commit_head = 0; tail = DEPTH (wrap bit set), so the list is full.
  - free_count = DEPTH; alloc_valid = 1; alloc_phys = 32; both error flags = 0.
  - Reset mid-operation discards all state immediately.
- Allocate:
  - alloc_fire = alloc_req && alloc_valid.
  - On alloc_fire, spec_head increments at the clock edge. alloc_phys is the pre-increment head entry, so the ID is used in the same cycle and the next ID appears on the following cycle.
  - alloc_req while empty: no pointer change and no error; rename stalls on alloc_valid=0.
- Commit:
  - On commit_en, commit_old_phys is written to entry[tail], then tail increments and commit_head increments.
  - A commit while full sets err_overflow; the write and tail increment are suppressed and commit_head still advances.
  - A commit while commit_head == spec_head sets err_underflow; commit_head does not advance, and the release still proceeds if not full.
- No bypass: a register released this cycle is not allocatable until the next cycle, even when the list was empty.
- Flush:
  - spec_head <= commit_head_next, where commit_head_next includes a same-cycle commit increment.
  - alloc_valid is forced 0 during the flush cycle, so any alloc_req is ignored.
  - A simultaneous commit is fully performed, because the committing instruction is older than the flush.
- Simultaneous alloc_fire and commit_en: both pointers move and free_count is unchanged.
- free_count = tail - spec_head, computed with the full pointer width including the wrap bit, registered or derived from registered pointers (no combinational path from inputs).
- Wrap-around: pointer arithmetic is modulo 2*DEPTH and the index is the low bits. DEPTH must be a power of two.

Decomposition:
- Shared package (riscv_header.sv): NUM_PHYS_REGS, NUM_ARCH_REGS (alias of NUM_INT_REGS), PHYS_W, and typedef phys_id_t = logic [PHYS_W-1:0].
- No sub-module: the pointer/full/empty logic is small and stays inline in phys_free_list.

Test Plan:
- Reset, then alloc_req=1 for 32 cycles, commit_en=0 -> alloc_phys = 32,33,...,63 in order; after the 32nd fire alloc_valid=0 and free_count=0.
- List empty, commit_en=1 with commit_old_phys=5 -> alloc_valid stays 0 that cycle, is 1 the next cycle with alloc_phys=5 and free_count=1.
- From reset, allocate 4 (32..35), commit 1 (old_phys=7), then flush -> next cycle spec_head=commit_head+... such that free_count=32-4+1+3=32; alloc order resumes 33,34,35,...,63,7.
- Flush asserted together with alloc_req=1 and commit_en=1 (old_phys=9) -> no allocation; the commit is counted; 9 is appended at the tail.
- From reset (full), commit_en=1 with old_phys=12 -> err_overflow=1 and stays 1; free_count stays 32; entries are unchanged.
- Run 200 random alloc/commit cycles with rst pulsed asynchronously mid-stream -> all outputs return to reset values immediately; each ID from 32..63 is allocated at most once between releases.

Source files
------------

// File: rtl/phys_free_list_pkg.sv
// phys_free_list_pkg: shared register-file sizing and ID types for the rename free list
package phys_free_list_pkg;
  localparam int NUM_PHYS_REGS = 64;
  localparam int NUM_INT_REGS = 32;
  localparam int NUM_ARCH_REGS = NUM_INT_REGS;
  localparam int PHYS_W = $clog2(NUM_PHYS_REGS);
  localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int PTR_W = $clog2(DEPTH) + 1;
  typedef logic [PHYS_W-1:0] phys_id_t;
  typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/phys_free_list.sv
// phys_free_list: circular free list of physical register IDs with speculative and committed heads
module phys_free_list
  import phys_free_list_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  output logic              alloc_valid,
  output logic [PHYS_W-1:0] alloc_phys,
  input  logic              commit_en,
  input  logic [PHYS_W-1:0] commit_old_phys,
  input  logic              flush,
  output logic [PHYS_W-1:0] free_count,
  output logic              err_overflow,
  output logic              err_underflow
);
  phys_id_t entry [DEPTH];
  ptr_t spec_head, commit_head, tail, commit_head_next;
  logic empty, full, alloc_fire, release_ok, underflow;
  assign empty = spec_head == tail;
  assign full = spec_head[PTR_W-2:0] == tail[PTR_W-2:0] && spec_head[PTR_W-1] != tail[PTR_W-1];
  assign alloc_valid = !empty && !flush;
  assign alloc_phys = entry[spec_head[PTR_W-2:0]];
  assign alloc_fire = alloc_req && alloc_valid;
  assign underflow = commit_en && commit_head == spec_head;
  assign release_ok = commit_en && !full;
  // flush rewinds to the committed head including any commit landing this same cycle
  assign commit_head_next = commit_head + ptr_t'(commit_en && !underflow);
  assign free_count = PHYS_W'(tail - spec_head);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entry[i] <= phys_id_t'(NUM_ARCH_REGS + i);
      spec_head <= '0;
      commit_head <= '0;
      tail <= ptr_t'(DEPTH);
      err_overflow <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (release_ok) entry[tail[PTR_W-2:0]] <= commit_old_phys;
      tail <= tail + ptr_t'(release_ok);
      commit_head <= commit_head_next;
      spec_head <= flush ? commit_head_next : spec_head + ptr_t'(alloc_fire);
      err_overflow <= err_overflow || (commit_en && full);
      err_underflow <= err_underflow || underflow;
    end
endmodule

// File: tb/tb_phys_free_list.sv
// tb_phys_free_list: directed and model-checked random stimulus for phys_free_list
module tb_phys_free_list;
  import phys_free_list_pkg::*;
  logic clk = 1'b0;
  logic rst, alloc_req, alloc_valid, commit_en, flush, err_overflow, err_underflow;
  logic [PHYS_W-1:0] alloc_phys, commit_old_phys, free_count;
  int total = 0;
  int bad = 0;
  int free_q[$];
  int live_q[$];
  int outstanding;
  logic live_bit [NUM_PHYS_REGS];
  always #5 clk = ~clk;
  phys_free_list dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_valid(alloc_valid),
    .alloc_phys(alloc_phys), .commit_en(commit_en), .commit_old_phys(commit_old_phys),
    .flush(flush), .free_count(free_count), .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic a, input logic c, input int p, input logic f);
    alloc_req = a;
    commit_en = c;
    commit_old_phys = PHYS_W'(p);
    flush = f;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset_and_check(input string tag);
    drive(0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk({tag, "_free"}, 32'(free_count), 32'(DEPTH));
    chk({tag, "_valid"}, 32'(alloc_valid), 1);
    chk({tag, "_phys"}, 32'(alloc_phys), 32'(NUM_ARCH_REGS));
    chk({tag, "_ovf"}, 32'(err_overflow), 0);
    chk({tag, "_unf"}, 32'(err_underflow), 0);
    rst = 1'b0;
  endtask
  task automatic model_reset;
    free_q.delete();
    live_q.delete();
    outstanding = 0;
    for (int i = 0; i < NUM_PHYS_REGS; i++) live_bit[i] = (i < NUM_ARCH_REGS);
    for (int i = 0; i < NUM_ARCH_REGS; i++) live_q.push_back(i);
    for (int i = NUM_ARCH_REGS; i < NUM_PHYS_REGS; i++) free_q.push_back(i);
  endtask
  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0);
    #10;
    pulse_reset_and_check("reset");
    tick;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 0, 0);
      chk("drain_valid", 32'(alloc_valid), 1);
      chk("drain_phys", 32'(alloc_phys), 32'(NUM_ARCH_REGS + i));
      tick;
    end
    drive(1, 0, 0, 0);
    chk("empty_valid", 32'(alloc_valid), 0);
    chk("empty_free", 32'(free_count), 0);
    tick;
    chk("empty_req_free", 32'(free_count), 0);
    chk("empty_req_unf", 32'(err_underflow), 0);
    drive(0, 1, 5, 0);
    chk("nobypass_valid", 32'(alloc_valid), 0);
    tick;
    drive(0, 0, 0, 0);
    chk("release_valid", 32'(alloc_valid), 1);
    chk("release_phys", 32'(alloc_phys), 5);
    chk("release_free", 32'(free_count), 1);
    pulse_reset_and_check("rst2");
    tick;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0);
      chk("fl_alloc_phys", 32'(alloc_phys), 32'(32 + i));
      tick;
    end
    drive(0, 1, 7, 0);
    tick;
    drive(0, 0, 0, 1);
    chk("fl_valid", 32'(alloc_valid), 0);
    tick;
    drive(0, 0, 0, 0);
    chk("fl_free", 32'(free_count), 32);
    for (int i = 0; i < 31; i++) begin
      drive(1, 0, 0, 0);
      chk("fl_resume_phys", 32'(alloc_phys), 32'(33 + i));
      tick;
    end
    drive(1, 0, 0, 0);
    chk("fl_tail_phys", 32'(alloc_phys), 7);
    tick;
    pulse_reset_and_check("rst3");
    tick;
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0);
      tick;
    end
    drive(1, 1, 9, 1);
    chk("flc_valid", 32'(alloc_valid), 0);
    tick;
    drive(0, 0, 0, 0);
    chk("flc_free", 32'(free_count), 32);
    chk("flc_phys", 32'(alloc_phys), 33);
    chk("flc_unf", 32'(err_underflow), 0);
    for (int i = 0; i < 31; i++) begin
      drive(1, 0, 0, 0);
      chk("flc_resume_phys", 32'(alloc_phys), 32'(33 + i));
      tick;
    end
    drive(0, 0, 0, 0);
    chk("flc_tail_phys", 32'(alloc_phys), 9);
    pulse_reset_and_check("rst4");
    tick;
    drive(0, 1, 12, 0);
    tick;
    drive(0, 0, 0, 0);
    chk("ovf_flag", 32'(err_overflow), 1);
    chk("ovf_unf_flag", 32'(err_underflow), 1);
    chk("ovf_free", 32'(free_count), 32);
    tick;
    tick;
    chk("ovf_sticky", 32'(err_overflow), 1);
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0);
      chk("ovf_entries", 32'(alloc_phys), 32'(32 + i));
      tick;
    end
    pulse_reset_and_check("rst5");
    model_reset();
    tick;
    for (int cyc = 0; cyc < 200; cyc++) begin
      logic a, c;
      int cp;
      a = 1'($urandom_range(0, 1));
      c = (outstanding > 0) && ($urandom_range(0, 2) != 0);
      cp = c ? live_q[0] : 0;
      drive(a, c, cp, 0);
      chk("rnd_valid", 32'(alloc_valid), 32'(free_q.size() > 0));
      chk("rnd_free", 32'(free_count), 32'(free_q.size()));
      if (free_q.size() > 0) begin
        chk("rnd_phys", 32'(alloc_phys), 32'(free_q[0]));
        chk("rnd_unique", 32'(live_bit[alloc_phys]), 0);
      end
      tick;
      if (a && free_q.size() > 0) begin
        int id;
        id = free_q.pop_front();
        live_q.push_back(id);
        live_bit[id] = 1'b1;
        outstanding++;
      end
      if (c) begin
        int id;
        id = live_q.pop_front();
        live_bit[id] = 1'b0;
        free_q.push_back(id);
        outstanding--;
      end
      if (cyc == 100) begin
        pulse_reset_and_check("rnd_rst");
        model_reset();
      end
    end
    drive(0, 0, 0, 0);
    chk("rnd_ovf", 32'(err_overflow), 0);
    chk("rnd_unf", 32'(err_underflow), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
